// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: FIFO-buffered UART transmitter with runtime baud divisor, parity and stop-bit selection.
module uart_tx_cfg #(
    parameter int DATA_W     = 8,
    parameter int DB_W       = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trmt,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DB_W-1:0]   DB,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              TX,
    output logic              tx_done,
    output logic              busy,
    output logic              fifo_full,
    output logic              overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = DATA_W + 3;
    localparam int NW = $clog2(DATA_W + 5);
    localparam logic [CW-1:0] FULL_CNT = FIFO_DEPTH[CW-1:0];

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d, tx_q, tx_d, tx_done_q, tx_done_d;
    logic [SW-1:0]     sh_q, sh_d;
    logic [DB_W-1:0]   cnt_q, cnt_d, db_q, db_d, db_eff;
    logic [NW-1:0]     bit_q, bit_d, n_q, n_d, n_new;
    logic [DATA_W-1:0] head;
    logic              full, empty, push, pop, par_en, par_bit;

    assign head     = mem_q[rd_ptr_q];
    assign full     = count_q == FULL_CNT;
    assign empty    = count_q == '0;
    assign push     = trmt & ~full;
    assign par_en   = ^parity_mode;
    assign par_bit  = ^head ^ parity_mode[1];
    assign db_eff   = (DB < DB_W'(2)) ? DB_W'(2) : DB;
    assign n_new    = NW'(DATA_W + 2) + NW'(par_en) + NW'(stop2);
    assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign count_d  = count_q + CW'(push) - CW'(pop);
    // A push against a full queue is dropped even if a pop frees a slot on the same edge.
    assign overflow_d = overflow_q | (trmt & full);

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q + DB_W'(1);
        bit_d     = bit_q;
        db_d      = db_q;
        n_d       = n_q;
        tx_done_d = 1'b0;
        pop       = 1'b0;
        if (state_q == IDLE) begin
            pop = ~empty;
        end else if (cnt_q == db_q - DB_W'(1)) begin
            cnt_d = '0;
            if (bit_q == n_q - NW'(1)) begin
                tx_done_d = 1'b1;
                pop       = ~empty;
                state_d   = IDLE;
                tx_d      = 1'b1;
            end else begin
                bit_d = bit_q + NW'(1);
                tx_d  = sh_q[0];
                sh_d  = {1'b1, sh_q[SW-1:1]};
            end
        end
        if (pop) begin
            state_d = SHIFT;
            tx_d    = 1'b0;
            sh_d    = {2'b11, par_en ? par_bit : 1'b1, head};
            cnt_d   = '0;
            bit_d   = '0;
            db_d    = db_eff;
            n_d     = n_new;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
            sh_q       <= '1;
            cnt_q      <= '0;
            db_q       <= DB_W'(2);
            bit_q      <= '0;
            n_q        <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            db_q       <= db_d;
            bit_q      <= bit_d;
            n_q        <= n_d;
        end
    end

    assign TX        = tx_q;
    assign tx_done   = tx_done_q;
    assign busy      = state_q == SHIFT;
    assign fifo_full = full;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg; expected frames are queued at push time and
// compared against frames captured from the TX line.
module tb_uart_tx_cfg;
    typedef struct {
        logic [15:0] bits;
        int          n;
        int          db;
    } frame_t;

    logic        clk = 1'b0, rst = 1'b1, trmt = 1'b0, stop2 = 1'b0;
    logic [7:0]  tx_data = '0;
    logic [12:0] DB = 13'd4;
    logic [1:0]  parity_mode = 2'b00;
    logic        TX, tx_done, busy, fifo_full, overflow;
    int          tests_run = 0, tests_failed = 0, cyc = 0, busy_cnt = 0;
    int          done_q[$];
    frame_t      exp_q[$];
    logic [7:0]  pbuf [8];

    uart_tx_cfg #(.DATA_W(8), .DB_W(13), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data), .DB(DB),
        .parity_mode(parity_mode), .stop2(stop2), .TX(TX), .tx_done(tx_done),
        .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_q.push_back(cyc);
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic frame_t mk(input logic [7:0] d, input logic [1:0] pm, input logic s2, input int db);
        frame_t f;
        int k;
        f.bits = '0;
        for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
        k = 9;
        if (pm == 2'b01) begin f.bits[k] = ^d; k++; end
        else if (pm == 2'b10) begin f.bits[k] = ~^d; k++; end
        f.bits[k] = 1'b1; k++;
        if (s2) begin f.bits[k] = 1'b1; k++; end
        f.n = k;
        f.db = (db < 2) ? 2 : db;
        return f;
    endfunction

    task automatic push_seq(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            trmt = 1'b1;
            tx_data = pbuf[i];
            @(negedge clk);
        end
        trmt = 1'b0;
    endtask

    // Waits for a start bit (bounded), then samples every cycle of the frame.
    task automatic rx_frame(input int n, input int db, output logic [15:0] bits, output bit clean, output int start);
        int t;
        bits = '0;
        clean = 1'b1;
        start = -1;
        t = 0;
        while (TX !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
        if (TX !== 1'b0) begin bits = '1; clean = 1'b0; return; end
        start = cyc;
        for (int i = 0; i < n * db; i++) begin
            if (i > 0) @(negedge clk);
            if (i % db == 0) bits[i/db] = TX;
            else if (TX !== bits[i/db]) clean = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++; if (TX !== 1'b1) begin tests_failed++; $display("FAIL reset_tx got=%b exp=1", TX); end
        tests_run++; if ({tx_done, busy, fifo_full, overflow} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags got=%b exp=0000", {tx_done, busy, fifo_full, overflow}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_8n1();
        frame_t f;
        logic [15:0] b;
        bit cl;
        int s, es, d0, b0;
        DB = 13'd4; parity_mode = 2'b00; stop2 = 1'b0;
        exp_q.push_back(mk(8'hA5, 2'b00, 1'b0, 4));
        pbuf[0] = 8'hA5;
        d0 = done_q.size(); b0 = busy_cnt; es = cyc + 2;
        fork push_seq(1); join_none
        f = exp_q.pop_front();
        rx_frame(f.n, f.db, b, cl, s);
        repeat (5) @(negedge clk);
        tests_run++; if (s !== es) begin tests_failed++; $display("FAIL 8n1_start got=%0d exp=%0d", s, es); end
        tests_run++; if (b !== f.bits) begin tests_failed++; $display("FAIL 8n1_bits got=%b exp=%b", b, f.bits); end
        tests_run++; if (b[9:0] !== 10'b1101001010) begin tests_failed++; $display("FAIL 8n1_pattern got=%b exp=1101001010", b[9:0]); end
        tests_run++; if (!cl) begin tests_failed++; $display("FAIL 8n1_bit_width got=unstable exp=4clk"); end
        tests_run++; if (done_q.size() - d0 !== 1) begin tests_failed++; $display("FAIL 8n1_done_count got=%0d exp=1", done_q.size() - d0); end
        else begin
            tests_run++; if (done_q[d0] !== s + 40) begin tests_failed++; $display("FAIL 8n1_done_time got=%0d exp=%0d", done_q[d0], s + 40); end
        end
        tests_run++; if (busy_cnt - b0 !== 40) begin tests_failed++; $display("FAIL 8n1_busy got=%0d exp=40", busy_cnt - b0); end
    endtask

    task automatic test_parity_stop();
        frame_t f;
        logic [15:0] b;
        bit cl;
        int s, d0;
        logic [1:0] pms [3] = '{2'b01, 2'b10, 2'b01};
        logic       s2s [3] = '{1'b0, 1'b0, 1'b1};
        logic       pexp [3] = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            DB = 13'd4; parity_mode = pms[k]; stop2 = s2s[k];
            exp_q.push_back(mk(8'h07, pms[k], s2s[k], 4));
            pbuf[0] = 8'h07;
            d0 = done_q.size();
            fork push_seq(1); join_none
            f = exp_q.pop_front();
            rx_frame(f.n, f.db, b, cl, s);
            repeat (5) @(negedge clk);
            tests_run++; if (b !== f.bits || !cl) begin tests_failed++; $display("FAIL par_frame%0d got=%b clean=%0d exp=%b", k, b, cl, f.bits); end
            tests_run++; if (b[9] !== pexp[k]) begin tests_failed++; $display("FAIL par_bit%0d got=%b exp=%b", k, b[9], pexp[k]); end
            tests_run++; if (done_q.size() - d0 !== 1 || done_q[done_q.size()-1] !== s + 4 * f.n) begin tests_failed++; $display("FAIL par_done%0d got=%0d exp=%0d", k, done_q.size() > 0 ? done_q[done_q.size()-1] : -1, s + 4 * f.n); end
        end
        tests_run++; if (f.n !== 12 || b[11:10] !== 2'b11) begin tests_failed++; $display("FAIL stop2_len got=%0d/%b exp=12/11", f.n, b[11:10]); end
        parity_mode = 2'b00; stop2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        frame_t f;
        logic [15:0] b;
        bit cl;
        int s, s1, es, d0, b0;
        DB = 13'd4;
        pbuf[0] = 8'h11; pbuf[1] = 8'h22; pbuf[2] = 8'h33;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(pbuf[i], 2'b00, 1'b0, 4));
        d0 = done_q.size(); b0 = busy_cnt; es = cyc + 2; s1 = es;
        fork push_seq(3); join_none
        for (int i = 0; i < 3; i++) begin
            f = exp_q.pop_front();
            rx_frame(f.n, f.db, b, cl, s);
            tests_run++; if (s !== es || b !== f.bits || !cl) begin tests_failed++; $display("FAIL b2b_frame%0d got=%0d/%b exp=%0d/%b", i, s, b, es, f.bits); end
            es = es + 40;
        end
        repeat (5) @(negedge clk);
        tests_run++; if (done_q.size() - d0 !== 3) begin tests_failed++; $display("FAIL b2b_done_count got=%0d exp=3", done_q.size() - d0); end
        else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++; if (done_q[d0+i] !== s1 + 40 * (i + 1)) begin tests_failed++; $display("FAIL b2b_done%0d got=%0d exp=%0d", i, done_q[d0+i], s1 + 40 * (i + 1)); end
            end
        end
        tests_run++; if (busy_cnt - b0 !== 120) begin tests_failed++; $display("FAIL b2b_busy got=%0d exp=120", busy_cnt - b0); end
    endtask

    task automatic test_overflow();
        frame_t f;
        logic [15:0] b;
        bit cl;
        int s, d0;
        bit idle;
        DB = 13'd100;
        pbuf[0] = 8'h81; pbuf[1] = 8'h42; pbuf[2] = 8'h24; pbuf[3] = 8'h18; pbuf[4] = 8'hF0; pbuf[5] = 8'h0F;
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(pbuf[i], 2'b00, 1'b0, 100));
        d0 = done_q.size();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    trmt = 1'b1;
                    tx_data = pbuf[i];
                    @(negedge clk);
                    if (i == 3) begin tests_run++; if (fifo_full !== 1'b0) begin tests_failed++; $display("FAIL ovf_full4 got=%b exp=0", fifo_full); end end
                    if (i == 4) begin tests_run++; if ({fifo_full, overflow} !== 2'b10) begin tests_failed++; $display("FAIL ovf_full5 got=%b exp=10", {fifo_full, overflow}); end end
                    if (i == 5) begin tests_run++; if ({fifo_full, overflow} !== 2'b11) begin tests_failed++; $display("FAIL ovf_set6 got=%b exp=11", {fifo_full, overflow}); end end
                end
                trmt = 1'b0;
            end
        join_none
        for (int i = 0; i < 5; i++) begin
            f = exp_q.pop_front();
            rx_frame(f.n, f.db, b, cl, s);
            tests_run++; if (b !== f.bits || !cl) begin tests_failed++; $display("FAIL ovf_frame%0d got=%b exp=%b", i, b, f.bits); end
        end
        idle = 1'b1;
        repeat (300) begin @(negedge clk); if (TX !== 1'b1) idle = 1'b0; end
        tests_run++; if (!idle || busy !== 1'b0) begin tests_failed++; $display("FAIL ovf_dropped got=idle%0d busy%b exp=idle1 busy0", idle, busy); end
        tests_run++; if (done_q.size() - d0 !== 5) begin tests_failed++; $display("FAIL ovf_done_count got=%0d exp=5", done_q.size() - d0); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_clamp_capture();
        frame_t f;
        logic [15:0] b;
        bit cl;
        int s, s1, d0;
        DB = 13'd0;
        exp_q.push_back(mk(8'h3C, 2'b00, 1'b0, 0));
        pbuf[0] = 8'h3C;
        d0 = done_q.size();
        fork push_seq(1); join_none
        f = exp_q.pop_front();
        rx_frame(f.n, f.db, b, cl, s);
        repeat (5) @(negedge clk);
        tests_run++; if (b !== f.bits || !cl) begin tests_failed++; $display("FAIL clamp_frame got=%b clean=%0d exp=%b", b, cl, f.bits); end
        tests_run++; if (done_q.size() - d0 !== 1 || done_q[done_q.size()-1] !== s + 20) begin tests_failed++; $display("FAIL clamp_done got=%0d exp=%0d", done_q[done_q.size()-1], s + 20); end
        DB = 13'd4;
        pbuf[0] = 8'h5A; pbuf[1] = 8'hC3;
        exp_q.push_back(mk(8'h5A, 2'b00, 1'b0, 4));
        exp_q.push_back(mk(8'hC3, 2'b00, 1'b0, 8));
        d0 = done_q.size();
        fork
            begin
                push_seq(2);
                repeat (10) @(negedge clk);
                DB = 13'd8;
            end
        join_none
        f = exp_q.pop_front();
        rx_frame(f.n, f.db, b, cl, s1);
        tests_run++; if (b !== f.bits || !cl) begin tests_failed++; $display("FAIL cap_frame1 got=%b clean=%0d exp=%b", b, cl, f.bits); end
        f = exp_q.pop_front();
        rx_frame(f.n, f.db, b, cl, s);
        repeat (5) @(negedge clk);
        tests_run++; if (b !== f.bits || !cl || s !== s1 + 40) begin tests_failed++; $display("FAIL cap_frame2 got=%b@%0d exp=%b@%0d", b, s, f.bits, s1 + 40); end
        tests_run++; if (done_q.size() - d0 !== 2 || done_q[done_q.size()-1] !== s1 + 120) begin tests_failed++; $display("FAIL cap_done got=%0d exp=%0d", done_q[done_q.size()-1], s1 + 120); end
    endtask

    task automatic test_reset_mid_frame();
        int s, d0, b0;
        bit idle;
        DB = 13'd4;
        for (int i = 0; i < 6; i++) pbuf[i] = 8'h00;
        d0 = done_q.size();
        s = cyc + 2;
        push_seq(6);
        while (cyc < s + 17) @(negedge clk);
        tests_run++; if ({TX, busy, overflow} !== 3'b011) begin tests_failed++; $display("FAIL rst_pre got=%b exp=011", {TX, busy, overflow}); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if ({TX, busy, tx_done, fifo_full, overflow} !== 5'b10000) begin tests_failed++; $display("FAIL rst_async got=%b exp=10000", {TX, busy, tx_done, fifo_full, overflow}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        b0 = busy_cnt;
        idle = 1'b1;
        repeat (100) begin @(negedge clk); if (TX !== 1'b1) idle = 1'b0; end
        tests_run++; if (!idle || busy_cnt !== b0) begin tests_failed++; $display("FAIL rst_fifo_empty got=idle%0d busy%0d exp=idle1 busy0", idle, busy_cnt - b0); end
        tests_run++; if (done_q.size() !== d0) begin tests_failed++; $display("FAIL rst_no_done got=%0d exp=0", done_q.size() - d0); end
        tests_run++; if ({fifo_full, overflow} !== 2'b00) begin tests_failed++; $display("FAIL rst_post_flags got=%b exp=00", {fifo_full, overflow}); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_stop();
        test_back_to_back();
        test_overflow();
        test_clamp_capture();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
